// File: rtl/intr_ctrl_if.sv
// Bundle of the CPU-facing interrupt signals and the two external sources.
// The slave modport belongs to intr_ctrl; the master side is the CPU/environment.
interface intr_ctrl_if;
    logic       intr1;
    logic       intr2;
    logic       en;
    logic       ack;
    logic       eoi;
    logic       irq;
    logic [9:0] vector;
    logic [1:0] in_service;
    logic [7:0] lost;

    modport master (
        output intr1, intr2, en, ack, eoi,
        input  irq, vector, in_service, lost
    );

    modport slave (
        input  intr1, intr2, en, ack, eoi,
        output irq, vector, in_service, lost
    );
endinterface

// File: rtl/intr_ctrl.sv
// Two-source edge-triggered interrupt controller: pend latches, fixed priority
// (source 1 first), REQ/SERVICE handshake with the CPU, saturating lost-edge count.
module intr_ctrl #(
    parameter logic [9:0] VEC1 = 10'h3F0,
    parameter logic [9:0] VEC2 = 10'h3F8
) (
    input  logic        clk,
    input  logic        reset,
    intr_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t      state_r;
    logic        sel_r;          // 1'b0 = source 1, 1'b1 = source 2
    logic [1:0]  prev_r;
    logic [1:0]  pend_r;
    logic [7:0]  lost_r;
    logic        irq_r;
    logic [9:0]  vector_r;
    logic [1:0]  in_service_r;

    logic [1:0]  intr_s;
    logic [1:0]  edge_s;
    logic [1:0]  clr_s;
    logic [1:0]  pend_nxt_s;
    logic [1:0]  lost_hit_s;
    logic [1:0]  lost_inc_s;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] sum;
        sum      = {1'b0, a} + {7'b0000000, b};
        sat_add8 = sum[8] ? 8'hFF : sum[7:0];
    endfunction

    function automatic logic [1:0] onehot_sel(input logic sel);
        onehot_sel = sel ? 2'b10 : 2'b01;
    endfunction

    assign intr_s = {bus.intr2, bus.intr1};

    // Edge detection, pend set/clear and lost-edge accounting for this cycle.
    always_comb begin
        edge_s     = intr_s & ~prev_r;
        clr_s      = 2'b00;
        if (state_r == ST_REQ && bus.ack) begin
            clr_s = onehot_sel(sel_r);
        end else begin
            clr_s = 2'b00;
        end
        // A new edge beats a simultaneous ack-clear and is then not counted as lost.
        pend_nxt_s = edge_s | (pend_r & ~clr_s);
        lost_hit_s = edge_s & pend_r & ~clr_s;
        lost_inc_s = {1'b0, lost_hit_s[0]} + {1'b0, lost_hit_s[1]};
    end

    // Source history, pending latches and saturating lost counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_r <= 2'b00;
            pend_r <= 2'b00;
            lost_r <= 8'd0;
        end else begin
            prev_r <= intr_s;
            pend_r <= pend_nxt_s;
            lost_r <= sat_add8(lost_r, lost_inc_s);
        end
    end

    // Request/service FSM with registered irq, vector and in_service.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            sel_r        <= 1'b0;
            irq_r        <= 1'b0;
            vector_r     <= 10'h000;
            in_service_r <= 2'b00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.en && (pend_r != 2'b00)) begin
                        state_r  <= ST_REQ;
                        sel_r    <= ~pend_r[0];
                        irq_r    <= 1'b1;
                        vector_r <= pend_r[0] ? VEC1 : VEC2;
                    end else begin
                        irq_r    <= 1'b0;
                        vector_r <= 10'h000;
                    end
                    in_service_r <= 2'b00;
                end
                ST_REQ: begin
                    // sel stays frozen here, so a late source-1 edge cannot preempt.
                    if (bus.ack) begin
                        state_r      <= ST_SERVICE;
                        irq_r        <= 1'b0;
                        in_service_r <= onehot_sel(sel_r);
                    end else if (!bus.en) begin
                        state_r  <= ST_IDLE;
                        irq_r    <= 1'b0;
                        vector_r <= 10'h000;
                    end else begin
                        irq_r <= 1'b1;
                    end
                end
                ST_SERVICE: begin
                    if (bus.eoi) begin
                        state_r      <= ST_IDLE;
                        vector_r     <= 10'h000;
                        in_service_r <= 2'b00;
                    end else begin
                        in_service_r <= onehot_sel(sel_r);
                    end
                    irq_r <= 1'b0;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    sel_r        <= 1'b0;
                    irq_r        <= 1'b0;
                    vector_r     <= 10'h000;
                    in_service_r <= 2'b00;
                end
            endcase
        end
    end

    assign bus.irq        = irq_r;
    assign bus.vector     = vector_r;
    assign bus.in_service = in_service_r;
    assign bus.lost       = lost_r;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: one task per scenario, inline comparisons
// against hand-computed values.
module tb_intr_ctrl;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    intr_ctrl_if bus ();

    intr_ctrl #(.VEC1(10'h3F0), .VEC2(10'h3F8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 60 ns period, rising edges at 60, 120, 180 ...
    initial begin
        clk = 1'b0;
        #60;
        forever begin
            clk = 1'b1;
            #30;
            clk = 1'b0;
            #30;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.intr1 = 1'b0;
        bus.intr2 = 1'b0;
        bus.en    = 1'b0;
        bus.ack   = 1'b0;
        bus.eoi   = 1'b0;
    endtask

    task automatic pulse_reset;
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs();
        reset = 1'b1;
        #5;
        n_cmp++; if (bus.irq !== 1'b0) begin n_bad++; $display("FAIL rst_irq: got %b want 0", bus.irq); end
        n_cmp++; if (bus.vector !== 10'h000) begin n_bad++; $display("FAIL rst_vector: got %h want 000", bus.vector); end
        n_cmp++; if (bus.in_service !== 2'b00) begin n_bad++; $display("FAIL rst_insvc: got %b want 00", bus.in_service); end
        n_cmp++; if (bus.lost !== 8'd0) begin n_bad++; $display("FAIL rst_lost: got %0d want 0", bus.lost); end
        #5;
        reset = 1'b0;
    endtask

    task automatic test_basic;
        bus.en    = 1'b1;
        bus.intr1 = 1'b1;
        tick();   // 60 ns edge: pend1 set
        n_cmp++; if (bus.irq !== 1'b0) begin n_bad++; $display("FAIL basic_irq_early: got %b want 0", bus.irq); end
        tick();   // 120 ns edge: REQ
        bus.intr1 = 1'b0;
        n_cmp++; if (bus.irq !== 1'b1) begin n_bad++; $display("FAIL basic_irq: got %b want 1", bus.irq); end
        n_cmp++; if (bus.vector !== 10'h3F0) begin n_bad++; $display("FAIL basic_vector: got %h want 3f0", bus.vector); end
        bus.ack = 1'b1; tick(); bus.ack = 1'b0;
        n_cmp++; if (bus.in_service !== 2'b01 || bus.irq !== 1'b0) begin n_bad++; $display("FAIL basic_svc: got insvc=%b irq=%b want 01/0", bus.in_service, bus.irq); end
        n_cmp++; if (bus.vector !== 10'h3F0) begin n_bad++; $display("FAIL basic_svc_vector: got %h want 3f0", bus.vector); end
        bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
        n_cmp++; if (bus.in_service !== 2'b00 || bus.vector !== 10'h000) begin n_bad++; $display("FAIL basic_eoi: got insvc=%b vec=%h want 00/000", bus.in_service, bus.vector); end
    endtask

    task automatic test_both_sources;
        clear_inputs(); pulse_reset(); bus.en = 1'b1;
        bus.intr1 = 1'b1; bus.intr2 = 1'b1; tick();
        bus.intr1 = 1'b0; bus.intr2 = 1'b0; tick();
        n_cmp++; if (bus.irq !== 1'b1 || bus.vector !== 10'h3F0) begin n_bad++; $display("FAIL both_req1: got irq=%b vec=%h want 1/3f0", bus.irq, bus.vector); end
        bus.ack = 1'b1; tick(); bus.ack = 1'b0;
        n_cmp++; if (bus.in_service !== 2'b01) begin n_bad++; $display("FAIL both_svc1: got %b want 01", bus.in_service); end
        bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
        n_cmp++; if (bus.irq !== 1'b0 || bus.in_service !== 2'b00) begin n_bad++; $display("FAIL both_idle: got irq=%b insvc=%b want 0/00", bus.irq, bus.in_service); end
        tick();
        n_cmp++; if (bus.irq !== 1'b1 || bus.vector !== 10'h3F8) begin n_bad++; $display("FAIL both_req2: got irq=%b vec=%h want 1/3f8", bus.irq, bus.vector); end
        bus.ack = 1'b1; tick(); bus.ack = 1'b0;
        n_cmp++; if (bus.in_service !== 2'b10 || bus.vector !== 10'h3F8) begin n_bad++; $display("FAIL both_svc2: got insvc=%b vec=%h want 10/3f8", bus.in_service, bus.vector); end
        bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
        n_cmp++; if (bus.lost !== 8'd0) begin n_bad++; $display("FAIL both_lost: got %0d want 0", bus.lost); end
    endtask

    task automatic test_lost;
        clear_inputs(); pulse_reset(); bus.en = 1'b1;
        bus.intr1 = 1'b1; tick(); bus.intr1 = 1'b0; tick();
        bus.ack = 1'b1; tick(); bus.ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.intr2 = 1'b1; tick();
            bus.intr2 = 1'b0; tick();
        end
        n_cmp++; if (bus.lost !== 8'd2) begin n_bad++; $display("FAIL lost_count: got %0d want 2", bus.lost); end
        n_cmp++; if (bus.in_service !== 2'b01 || bus.irq !== 1'b0) begin n_bad++; $display("FAIL lost_nonest: got insvc=%b irq=%b want 01/0", bus.in_service, bus.irq); end
        bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
        n_cmp++; if (bus.irq !== 1'b0) begin n_bad++; $display("FAIL lost_idle_gap: got %b want 0", bus.irq); end
        tick();
        n_cmp++; if (bus.irq !== 1'b1 || bus.vector !== 10'h3F8) begin n_bad++; $display("FAIL lost_req2: got irq=%b vec=%h want 1/3f8", bus.irq, bus.vector); end
    endtask

    task automatic test_saturation;
        clear_inputs(); pulse_reset();
        for (int i = 0; i < 255; i++) begin
            bus.intr2 = 1'b1; tick();
            bus.intr2 = 1'b0; tick();
        end
        n_cmp++; if (bus.lost !== 8'd254) begin n_bad++; $display("FAIL sat_254: got %0d want 254", bus.lost); end
        for (int i = 0; i < 2; i++) begin
            bus.intr2 = 1'b1; tick();
            bus.intr2 = 1'b0; tick();
        end
        n_cmp++; if (bus.lost !== 8'd255) begin n_bad++; $display("FAIL sat_255: got %0d want 255", bus.lost); end
    endtask

    task automatic test_enable;
        clear_inputs(); pulse_reset();
        bus.intr1 = 1'b1; tick(); bus.intr1 = 1'b0; tick(); tick();
        n_cmp++; if (bus.irq !== 1'b0) begin n_bad++; $display("FAIL en_masked: got %b want 0", bus.irq); end
        bus.en = 1'b1; tick();
        n_cmp++; if (bus.irq !== 1'b1) begin n_bad++; $display("FAIL en_raise: got %b want 1", bus.irq); end
        bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
        n_cmp++; if (bus.irq !== 1'b1 || bus.in_service !== 2'b00) begin n_bad++; $display("FAIL en_eoi_ignored: got irq=%b insvc=%b want 1/00", bus.irq, bus.in_service); end
        bus.en = 1'b0; tick();
        n_cmp++; if (bus.irq !== 1'b0 || bus.vector !== 10'h000) begin n_bad++; $display("FAIL en_drop: got irq=%b vec=%h want 0/000", bus.irq, bus.vector); end
        bus.en = 1'b1; tick();
        n_cmp++; if (bus.irq !== 1'b1 || bus.vector !== 10'h3F0) begin n_bad++; $display("FAIL en_pend_kept: got irq=%b vec=%h want 1/3f0", bus.irq, bus.vector); end
        bus.en = 1'b0; bus.ack = 1'b1; tick(); bus.ack = 1'b0;
        n_cmp++; if (bus.in_service !== 2'b01) begin n_bad++; $display("FAIL en_ack_prec: got %b want 01", bus.in_service); end
        reset = 1'b1; #2;
        n_cmp++; if (bus.in_service !== 2'b00 || bus.irq !== 1'b0 || bus.vector !== 10'h000 || bus.lost !== 8'd0) begin n_bad++; $display("FAIL midsvc_reset: got insvc=%b irq=%b vec=%h lost=%0d want 00/0/000/0", bus.in_service, bus.irq, bus.vector, bus.lost); end
        reset = 1'b0;
    endtask

    task automatic test_no_preempt;
        clear_inputs(); pulse_reset(); bus.en = 1'b1;
        bus.ack = 1'b1; tick(); bus.ack = 1'b0;
        n_cmp++; if (bus.in_service !== 2'b00 || bus.irq !== 1'b0) begin n_bad++; $display("FAIL idle_ack_ignored: got insvc=%b irq=%b want 00/0", bus.in_service, bus.irq); end
        bus.intr2 = 1'b1; tick(); bus.intr2 = 1'b0; tick();
        bus.intr1 = 1'b1; tick(); bus.intr1 = 1'b0;
        n_cmp++; if (bus.vector !== 10'h3F8) begin n_bad++; $display("FAIL nopreempt_vec: got %h want 3f8", bus.vector); end
        bus.ack = 1'b1; tick(); bus.ack = 1'b0;
        n_cmp++; if (bus.in_service !== 2'b10) begin n_bad++; $display("FAIL nopreempt_svc: got %b want 10", bus.in_service); end
        bus.eoi = 1'b1; tick(); bus.eoi = 1'b0; tick();
        n_cmp++; if (bus.irq !== 1'b1 || bus.vector !== 10'h3F0) begin n_bad++; $display("FAIL nopreempt_next: got irq=%b vec=%h want 1/3f0", bus.irq, bus.vector); end
    endtask

    task automatic test_back_to_back;
        clear_inputs(); pulse_reset(); bus.en = 1'b1;
        bus.intr1 = 1'b1; tick(); bus.intr1 = 1'b0; tick();
        bus.intr1 = 1'b1; bus.ack = 1'b1; tick(); bus.intr1 = 1'b0; bus.ack = 1'b0;
        n_cmp++; if (bus.in_service !== 2'b01 || bus.lost !== 8'd0) begin n_bad++; $display("FAIL b2b_svc: got insvc=%b lost=%0d want 01/0", bus.in_service, bus.lost); end
        bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
        n_cmp++; if (bus.irq !== 1'b0) begin n_bad++; $display("FAIL b2b_gap: got %b want 0", bus.irq); end
        tick();
        n_cmp++; if (bus.irq !== 1'b1 || bus.vector !== 10'h3F0) begin n_bad++; $display("FAIL b2b_req: got irq=%b vec=%h want 1/3f0", bus.irq, bus.vector); end
    endtask

    task automatic test_held_across_reset;
        clear_inputs(); bus.en = 1'b1; bus.intr1 = 1'b1;
        pulse_reset();
        tick();
        n_cmp++; if (bus.irq !== 1'b0) begin n_bad++; $display("FAIL held_first: got %b want 0", bus.irq); end
        tick();
        n_cmp++; if (bus.irq !== 1'b1 || bus.vector !== 10'h3F0) begin n_bad++; $display("FAIL held_req: got irq=%b vec=%h want 1/3f0", bus.irq, bus.vector); end
        bus.intr1 = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_basic();
        test_both_sources();
        test_lost();
        test_saturation();
        test_enable();
        test_no_preempt();
        test_back_to_back();
        test_held_across_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 Parameter VEC1, default 10'h3F0: handler address for source 1.
REQ-002 Parameter VEC2, default 10'h3F8: handler address for source 2.
REQ-003 Port clk  input  1: system clock; all state updates on the rising edge.
REQ-004 Port reset  input  1: reset, asynchronous and active-high.
REQ-005 Port intr1  input  1: external interrupt source 1, rising-edge triggered, highest priority.
REQ-006 Port intr2  input  1: external interrupt source 2, rising-edge triggered.
REQ-007 Port en  input  1: CPU global interrupt enable.
REQ-008 Port ack  input  1: CPU accepts the presented interrupt (one-cycle pulse).
REQ-009 Port eoi  input  1: CPU end-of-interrupt / return (one-cycle pulse).
REQ-010 Port irq  output  1: interrupt request to the CPU.
REQ-011 Port vector  output  10: handler address for the selected source.
REQ-012 Port in_service  output  2: one-hot source in service; bit0 = source 1, bit1 = source 2.
REQ-013 Port lost  output  8: saturating count of coalesced (lost) edges.

Function
REQ-014 Edge detect: each source has a registered previous-value flop; an edge is intrN=1 with prevN=0 at a rising clk edge.
REQ-015 An edge sets pendN at that same clock edge, so pendN is visible one cycle after intrN is sampled high.
REQ-016 Edge on a source whose pendN is already 1: pendN is unchanged and lost increments by 1, saturating at 255.
REQ-017 Edges on both sources in the same cycle: both pend bits are set.
REQ-018 FSM states: IDLE, REQ, SERVICE; reset state is IDLE.
REQ-019 IDLE -> REQ at a clock edge where en=1 and (pend1|pend2)=1; sel is registered as source 1 if pend1=1, else source 2.
REQ-020 irq = 1 exactly while in REQ; irq therefore rises no earlier than one cycle after the pend bit sets.
REQ-021 REQ, ack=1 -> SERVICE: clear pend[sel], set in_service[sel], irq falls.
REQ-022 REQ, en=0 and ack=0 -> IDLE with pend bits unchanged; ack takes precedence over en=0 in the same cycle.
REQ-023 The sel value is frozen while in REQ; a source-1 edge arriving during REQ does not preempt a selected source 2.
REQ-024 SERVICE, eoi=1 -> IDLE and in_service cleared; no nesting, and pending edges wait for IDLE.
REQ-025 ack outside REQ and eoi outside SERVICE are ignored.
REQ-026 Clearing pend[sel] on ack while a new edge on the same source arrives in the same cycle: the set wins, pend stays 1, and lost does not increment.
REQ-027 vector = VEC1 or VEC2 per sel in REQ and SERVICE; vector = 10'h000 in IDLE.
REQ-028 Back-to-back: eoi with pend still set and en=1 yields IDLE for one cycle, then REQ on the next edge.

Reset
REQ-029 Asserting reset immediately forces IDLE, pend=2'b00, prev=2'b00, sel=source 1, and lost=0.
REQ-030 During reset the outputs are irq=0, vector=10'h000, in_service=2'b00, and lost=8'd0.
REQ-031 Reset mid-operation, in REQ or SERVICE, discards all pending and in-service state with no completion required.
REQ-032 An intrN held high across reset release is detected as an edge at the first clock edge after release, because prev is 0.

Verification
REQ-033 Bench: 60 ns clock, reset pulse of 10 ns, en=1, intr1 high at 60 ns then low at 120 ns -> pend1 set at 60 ns edge; irq=1 and vector=10'h3F0 from the 120 ns edge.
REQ-034 Bench: intr1 and intr2 rising on the same edge, ack, eoi, ack, eoi -> source 1 is serviced first, in_service=2'b01, then in_service=2'b10 with vector=10'h3F8; lost=0.
REQ-035 Bench: three intr2 pulses while in SERVICE for source 1 -> pend2=1, lost=2; source 2 is presented in REQ two cycles after eoi.
REQ-036 Bench: en=0 with pend1 set -> irq stays 0; raising en gives irq=1 the next cycle; dropping en in REQ without ack gives irq=0 and pend1 still 1.
REQ-037 Bench: reset asserted mid-SERVICE -> in_service=2'b00, irq=0, vector=10'h000 with no clock edge; lost=0.
REQ-038 Bench: ack in the same cycle as a new intr1 edge -> SERVICE for source 1, pend1=1, and a second REQ for source 1 after eoi.
